instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Fetch-side writer for the instruction register in the multicycle MIPS core. It holds the PC and issues word reads to instruction memory with a req/ready handshake. It presents the returned word on `instruction` with a one-cycle `ir_w` strobe, and applies branch and jump redirects from the control unit. It sits between the control FSM, the instruction memory and the instruction register.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- TIMEOUT_CYCLES, 16, cycles `mem_req` may stay unanswered before fault; used only with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_go  in  1  control FSM requests one instruction fetch.
- jump_en  in  1  load jump target into PC.
- jump_address  in  26  J-type target field.
- branch_en  in  1  apply branch offset to PC.
- branch_offset  in  16  signed word offset (I-type immediate).
- mem_req  out  1  read request to instruction memory.
- mem_addr  out  32  byte address of the read.
- mem_ready  in  1  memory has valid data this cycle.
- mem_rdata  in  32  read data.
- instruction  out  32  fetched word to instruction register.
- ir_w  out  1  one-cycle write strobe to instruction register.
- pc  out  32  current PC, i.e. address of the next fetch.
- busy  out  1  high in any state other than IDLE.
- fault  out  1  sticky fetch timeout flag.

Behaviour:
- **Reset** (rst_n=0, async): state=IDLE, pc=RESET_PC, mem_req=0, mem_addr=RESET_PC, instruction=0, ir_w=0, busy=0, fault=0.
- **States**: IDLE, REQ, ISSUE, FAULT (the last exists only with FETCH_TIMEOUT_EN).
- **Next-PC in IDLE** (combinational npc):
  - jump_en: {pc[31:28], jump_address, 2'b00}
  - else branch_en: pc + {{14{branch_offset[15]}}, branch_offset, 2'b00}
  - else: pc.
  - jump_en has priority over branch_en. pc <= npc every IDLE cycle.
- **Redirects outside IDLE**: jump_en and branch_en are ignored in all other states; the control FSM must check busy before redirecting.
- **IDLE -> REQ** on fetch_go:
  - mem_req <= 1, mem_addr <= npc.
  - A redirect and fetch_go in the same cycle fetch from the redirected address.
- **REQ**:
  - mem_req and mem_addr held stable until mem_ready is sampled high at a posedge.
  - On that edge: instruction <= mem_rdata, mem_req <= 0, ir_w <= 1, pc <= mem_addr + 4, state -> ISSUE.
  - fetch_go is ignored in REQ.
- **ISSUE**: ir_w <= 0, state -> IDLE. ir_w is high for exactly one cycle.
  - instruction holds its value until the next successful fetch, so it is stable across the negedge where the IR samples.
- **Latency**: with mem_ready tied high, ir_w rises 2 edges after the fetch_go edge. Each wait state adds 1 cycle.
- **PC arithmetic**:
  - All PC arithmetic is mod 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
  - pc[1:0] is always 00.
- **mem_ready outside REQ** is ignored.
- **Reset mid-fetch**: returns to IDLE immediately with reset values. A late mem_ready after reset is ignored.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- **Defined**:
  - A counter runs in REQ, cleared on entry to REQ.
  - If TIMEOUT_CYCLES edges pass without mem_ready: mem_req <= 0, fault <= 1, state -> FAULT, no ir_w.
  - FAULT is left only by reset; fetch_go and redirects are ignored there; busy=1.
- **Undefined**: REQ waits indefinitely, fault is tied 0, and no counter logic exists.

Test Plan:
- **Reset values**: assert rst_n=0 mid-cycle -> all outputs reach reset values without a clock edge; pc=0, mem_req=0, ir_w=0.
- **Zero-wait fetch**: mem_ready=1, mem_rdata=32'h8C22_0004, fetch_go pulse -> mem_addr=0 while mem_req is high; instruction=32'h8C22_0004 with ir_w high for 1 cycle, 2 edges after fetch_go; pc=4.
- **Wait states**: mem_ready held low 3 cycles -> mem_req/mem_addr stable throughout; ir_w 5 edges after fetch_go; fetch_go pulsed in REQ has no effect.
- **Jump**:
  - pc=32'h1000_0040, jump_en with jump_address=26'h000_0100 plus fetch_go -> mem_addr=32'h1000_0400, then pc=32'h1000_0404.
  - jump_en and branch_en together -> jump wins.
- **Branch and wrap**:
  - pc=32'h0000_0020, branch_offset=16'hFFF8 -> npc=32'h0000_0000.
  - Fetch at 32'hFFFF_FFFC -> pc wraps to 0.
- **Timeout** (FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4): mem_ready never asserted -> mem_req drops and fault=1 after 4 cycles, no ir_w; fetch_go is ignored until rst_n pulse clears fault.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit for the multicycle MIPS core.
// Owns the PC, issues word reads to instruction memory over a req/ready
// handshake, and hands the returned word to the IR with a one-cycle ir_w.
// Optional macro FETCH_TIMEOUT_EN adds a REQ watchdog with a sticky fault
// and a FAULT state that only reset leaves.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_go,
   input  logic        jump_en,
   input  logic [25:0] jump_address,
   input  logic        branch_en,
   input  logic [15:0] branch_offset,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic [31:0] instruction,
   output logic        ir_w,
   output logic [31:0] pc,
   output logic        busy,
   output logic        fault
);

`ifdef FETCH_TIMEOUT_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_ISSUE = 2'd2, S_FAULT = 2'd3} state_e;
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_ISSUE = 2'd2} state_e;
`endif

   // Elaboration-time parameter sanity
   if (RESET_PC[1:0] != 2'b00 || TIMEOUT_CYCLES == 0) begin : g_bad_param
      $error("instr_fetch_unit: RESET_PC must be word-aligned and TIMEOUT_CYCLES nonzero");
   end

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        mem_req_q, mem_req_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] instr_q, instr_d;
   logic        ir_w_q, ir_w_d;
   logic        busy_q, busy_d;
   logic [31:0] npc;
`ifdef FETCH_TIMEOUT_EN
   logic             fault_q, fault_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   // Redirect target: jump beats branch, otherwise hold
   always_comb begin
      npc = pc_q;
      if (jump_en) begin
         npc = {pc_q[31:28], jump_address, 2'b00};
      end else if (branch_en) begin
         npc = pc_q + {{14{branch_offset[15]}}, branch_offset, 2'b00};
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      instr_d    = instr_q;
      ir_w_d     = 1'b0;
`ifdef FETCH_TIMEOUT_EN
      fault_d    = fault_q;
      cnt_d      = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            pc_d = npc;
            if (fetch_go) begin
               mem_req_d  = 1'b1;
               mem_addr_d = npc;
               state_d    = S_REQ;
`ifdef FETCH_TIMEOUT_EN
               cnt_d      = '0;
`endif
            end
         end
         S_REQ: begin
            if (mem_ready) begin
               instr_d   = mem_rdata;
               mem_req_d = 1'b0;
               ir_w_d    = 1'b1;
               pc_d      = mem_addr_q + 32'd4;
               state_d   = S_ISSUE;
            end
`ifdef FETCH_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               mem_req_d = 1'b0;
               fault_d   = 1'b1;
               state_d   = S_FAULT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         S_ISSUE: begin
            state_d = S_IDLE;
         end
         default: begin
`ifndef FETCH_TIMEOUT_EN
            state_d = S_IDLE;
`endif
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         mem_req_q  <= 1'b0;
         mem_addr_q <= RESET_PC;
         instr_q    <= 32'h0;
         ir_w_q     <= 1'b0;
         busy_q     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         fault_q    <= 1'b0;
         cnt_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         instr_q    <= instr_d;
         ir_w_q     <= ir_w_d;
         busy_q     <= busy_d;
`ifdef FETCH_TIMEOUT_EN
         fault_q    <= fault_d;
         cnt_q      <= cnt_d;
`endif
      end
   end

   assign mem_req     = mem_req_q;
   assign mem_addr    = mem_addr_q;
   assign instruction = instr_q;
   assign ir_w        = ir_w_q;
   assign pc          = pc_q;
   assign busy        = busy_q;
`ifdef FETCH_TIMEOUT_EN
   assign fault       = fault_q;
`else
   assign fault       = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: vector table of redirect/fetch
// transactions plus hand-written reset-mid-fetch and timeout sequences.
module tb_instr_fetch_unit;

   localparam int unsigned TO_CYC = 4;

   logic        clk;
   logic        rst_n;
   logic        fetch_go;
   logic        jump_en;
   logic [25:0] jump_address;
   logic        branch_en;
   logic [15:0] branch_offset;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic [31:0] instruction;
   logic        ir_w;
   logic [31:0] pc;
   logic        busy;
   logic        fault;

   int n_checks = 0;
   int n_fail   = 0;

   instr_fetch_unit #(
      .RESET_PC      (32'h0000_0000),
      .TIMEOUT_CYCLES(TO_CYC)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .fetch_go     (fetch_go),
      .jump_en      (jump_en),
      .jump_address (jump_address),
      .branch_en    (branch_en),
      .branch_offset(branch_offset),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_ready    (mem_ready),
      .mem_rdata    (mem_rdata),
      .instruction  (instruction),
      .ir_w         (ir_w),
      .pc           (pc),
      .busy         (busy),
      .fault        (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        fetch;
      logic        jmp;
      logic [25:0] ja;
      logic        br;
      logic [15:0] bo;
      logic [31:0] rdata;
      int          waits;
      logic [31:0] exp_addr;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t vecs[10];

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic clr_redirect();
      jump_en       = 1'b0;
      jump_address  = 26'h0;
      branch_en     = 1'b0;
      branch_offset = 16'h0;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      logic seen;
      int   lat;
      seen = 1'b0;
      lat  = 0;
      jump_en       = v.jmp;
      jump_address  = v.ja;
      branch_en     = v.br;
      branch_offset = v.bo;
      if (!v.fetch) begin
         fetch_go = 1'b0;
         @(posedge clk);
         @(negedge clk);
         chk32($sformatf("v%0d idle_pc", idx), pc, v.exp_pc);
         chk1($sformatf("v%0d idle_req", idx), mem_req, 1'b0);
         chk1($sformatf("v%0d idle_busy", idx), busy, 1'b0);
         clr_redirect();
         return;
      end
      fetch_go  = 1'b1;
      mem_ready = 1'b1;
      mem_rdata = v.rdata;
      for (int e = 1; e <= v.waits + 4 && !seen; e++) begin
         @(posedge clk);
         @(negedge clk);
         if (e == 1) clr_redirect();
         if (ir_w) begin
            seen = 1'b1;
            lat  = e;
         end else begin
            chk1($sformatf("v%0d req_e%0d", idx, e), mem_req, 1'b1);
            chk32($sformatf("v%0d addr_e%0d", idx, e), mem_addr, v.exp_addr);
            fetch_go  = (e <= v.waits);
            mem_ready = (e == v.waits + 1);
         end
      end
      fetch_go  = 1'b0;
      mem_ready = 1'b0;
      if (!seen) begin
         n_checks++;
         n_fail++;
         $display("FAIL v%0d ir_w_timeout: ir_w never rose, expected at edge %0d", idx, v.waits + 2);
         return;
      end
      chk32($sformatf("v%0d latency", idx), 32'(lat), 32'(v.waits + 2));
      chk32($sformatf("v%0d instr", idx), instruction, v.rdata);
      chk32($sformatf("v%0d pc", idx), pc, v.exp_pc);
      chk1($sformatf("v%0d req_drop", idx), mem_req, 1'b0);
      chk1($sformatf("v%0d busy_issue", idx), busy, 1'b1);
      @(posedge clk);
      @(negedge clk);
      chk1($sformatf("v%0d ir_w_pulse", idx), ir_w, 1'b0);
      chk1($sformatf("v%0d busy_idle", idx), busy, 1'b0);
      chk32($sformatf("v%0d instr_hold", idx), instruction, v.rdata);
      chk1($sformatf("v%0d fault", idx), fault, 1'b0);
   endtask

   initial begin
      // fetch jmp ja br bo rdata waits exp_addr exp_pc
      vecs[0] = '{1'b1, 1'b0, 26'h0,       1'b0, 16'h0000, 32'h8C22_0004, 0, 32'h0000_0000, 32'h0000_0004};
      vecs[1] = '{1'b1, 1'b0, 26'h0,       1'b0, 16'h0000, 32'h2108_0001, 3, 32'h0000_0004, 32'h0000_0008};
      vecs[2] = '{1'b0, 1'b0, 26'h0,       1'b1, 16'h0006, 32'h0,         0, 32'h0,         32'h0000_0020};
      vecs[3] = '{1'b1, 1'b0, 26'h0,       1'b1, 16'hFFF8, 32'h0000_0020, 0, 32'h0000_0000, 32'h0000_0004};
      vecs[4] = '{1'b1, 1'b0, 26'h0,       1'b1, 16'hFFFE, 32'hAAAA_5555, 1, 32'hFFFF_FFFC, 32'h0000_0000};
      vecs[5] = '{1'b1, 1'b1, 26'h3FF_FFFF, 1'b0, 16'h0000, 32'h1234_5678, 0, 32'h0FFF_FFFC, 32'h1000_0000};
      vecs[6] = '{1'b0, 1'b0, 26'h0,       1'b1, 16'h0010, 32'h0,         0, 32'h0,         32'h1000_0040};
      vecs[7] = '{1'b1, 1'b1, 26'h000_0100, 1'b0, 16'h0000, 32'h0800_0100, 2, 32'h1000_0400, 32'h1000_0404};
      vecs[8] = '{1'b1, 1'b1, 26'h000_0010, 1'b1, 16'h0100, 32'h3C01_1000, 0, 32'h1000_0040, 32'h1000_0044};
      vecs[9] = '{1'b0, 1'b1, 26'h000_0020, 1'b1, 16'h0001, 32'h0,         0, 32'h0,         32'h1000_0080};

      rst_n     = 1'b0;
      fetch_go  = 1'b0;
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      clr_redirect();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk32("rst pc", pc, 32'h0);
      chk32("rst addr", mem_addr, 32'h0);
      chk32("rst instr", instruction, 32'h0);
      chk1("rst req", mem_req, 1'b0);
      chk1("rst ir_w", ir_w, 1'b0);
      chk1("rst busy", busy, 1'b0);
      chk1("rst fault", fault, 1'b0);

      for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

      // Reset asserted in the middle of a pending fetch
      fetch_go  = 1'b1;
      mem_ready = 1'b0;
      @(posedge clk);
      #1;
      fetch_go = 1'b0;
      chk1("mid req_up", mem_req, 1'b1);
      chk32("mid addr_up", mem_addr, 32'h1000_0080);
      #1 rst_n = 1'b0;
      #1;
      chk32("mid rst pc", pc, 32'h0);
      chk32("mid rst addr", mem_addr, 32'h0);
      chk32("mid rst instr", instruction, 32'h0);
      chk1("mid rst req", mem_req, 1'b0);
      chk1("mid rst ir_w", ir_w, 1'b0);
      chk1("mid rst busy", busy, 1'b0);
      @(negedge clk);
      rst_n     = 1'b1;
      mem_ready = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         @(negedge clk);
         chk1($sformatf("late_ready ir_w%0d", k), ir_w, 1'b0);
         chk1($sformatf("late_ready busy%0d", k), busy, 1'b0);
         chk32($sformatf("late_ready pc%0d", k), pc, 32'h0);
      end
      mem_ready = 1'b0;

`ifdef FETCH_TIMEOUT_EN
      begin
         int drop_e;
         logic saw_irw;
         drop_e  = 0;
         saw_irw = 1'b0;
         fetch_go = 1'b1;
         for (int e = 1; e <= 12 && drop_e == 0; e++) begin
            @(posedge clk);
            @(negedge clk);
            fetch_go = 1'b0;
            if (ir_w) saw_irw = 1'b1;
            if (!mem_req) drop_e = e;
         end
         chk32("to drop_edge", 32'(drop_e), 32'(TO_CYC + 1));
         chk1("to fault", fault, 1'b1);
         chk1("to busy", busy, 1'b1);
         chk1("to no_ir_w", saw_irw, 1'b0);
         fetch_go  = 1'b1;
         jump_en   = 1'b1;
         jump_address = 26'h000_0040;
         mem_ready = 1'b1;
         repeat (2) begin
            @(posedge clk);
            @(negedge clk);
         end
         fetch_go  = 1'b0;
         mem_ready = 1'b0;
         clr_redirect();
         chk1("to stuck req", mem_req, 1'b0);
         chk1("to stuck fault", fault, 1'b1);
         chk1("to stuck ir_w", ir_w, 1'b0);
         chk32("to stuck pc", pc, 32'h0);
         rst_n = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         @(negedge clk);
         chk1("to cleared fault", fault, 1'b0);
         chk1("to cleared busy", busy, 1'b0);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
